cache_mem_ctrl: RTL and testbench
=================================

# cache_mem_ctrl

Main-memory access controller sitting directly downstream of the cache controller FSM. It accepts one request at a time: a line-fill read on a cache miss or a single-word write-through. It models fixed main-memory latency with a countdown counter, then streams the line back word by word or commits the write. It signals completion with `data_ready_m` (line fill done) or `data_ready` (write-through done), the handshake inputs the cache FSM waits on.

## Interface
- `ADDR_W`, 8, word-address width
- `DATA_W`, 32, data word width
- `LINE_WORDS`, 4, words per cache line; power of two, ≥2
- `LATENCY`, 4, memory access wait cycles; ≥1
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present; requester holds it and all request fields stable until accepted
- `req_rw` in 1: 1 = write-through, 0 = line-fill read
- `req_addr` in ADDR_W: word address
- `req_wdata` in DATA_W: write data, used only when `req_rw`=1
- `req_ready` out 1: controller can accept a request
- `fill_valid` out 1: `fill_data` carries a line word this cycle
- `fill_index` out log2(LINE_WORDS): word offset within the line for the current beat
- `fill_data` out DATA_W: line word; 0 when `fill_valid`=0
- `data_ready_m` out 1: one-cycle pulse when a line fill is complete
- `data_ready` out 1: one-cycle pulse when a write-through is committed
- `busy` out 1: inverse of `req_ready`

## Operation
- Storage is an internal array of 2^ADDR_W words of DATA_W bits. Reset does not clear the array. The bench preloads it by writes.
- Acceptance: `req_valid`=1 and `req_ready`=1 at a rising edge. The controller captures `req_rw`, `req_addr` and `req_wdata` on that edge.
- Read base address is `req_addr` with the low log2(LINE_WORDS) bits forced to 0. Beats run in order, offset 0 to LINE_WORDS-1. No wrap outside the line is possible.
- State machine:
  - IDLE: `req_ready`=1. On acceptance, load the latency counter with LATENCY and go to WAIT.
  - WAIT: decrement the counter every cycle. When it reaches 0, go to FILL if the request is a read, or WRITE if it is a write. WAIT lasts exactly LATENCY cycles.
  - FILL: `fill_valid`=1. `fill_index` is the beat counter. `fill_data` = mem[base + beat]. The beat counter increments each cycle. After beat LINE_WORDS-1, go to DONE.
  - DONE: `data_ready_m`=1 for this one cycle, then go to IDLE.
  - WRITE: mem[addr] <= wdata on this edge, `data_ready`=1 for this one cycle, then go to IDLE.
- Illegal or unused state encodings go to IDLE.
- `req_valid` while busy is ignored and not queued. The requester holds it until `req_ready` is seen.
- Read-after-write: a fill accepted after a WRITE cycle returns the newly written value.
- `data_ready` and `data_ready_m` are never high in the same cycle.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1, `busy`=0 (from the cycle after `reset` is sampled)
  - `fill_valid`=0, `fill_index`=0, `fill_data`=0
  - `data_ready_m`=0, `data_ready`=0
  - counters 0
- `req_ready`=0 while `reset` is high.
- Acceptance edge at cycle A (state is IDLE during A):
  - WAIT occupies A+1 … A+LATENCY.
  - Read: beats k=0…LINE_WORDS-1 at A+LATENCY+1+k. `data_ready_m` at A+LATENCY+LINE_WORDS+1. IDLE, and `req_ready`=1, at A+LATENCY+LINE_WORDS+2.
  - Write: `data_ready` and the commit at A+LATENCY+1. IDLE at A+LATENCY+2.
- Minimum spacing between accepted requests: LATENCY+LINE_WORDS+2 cycles for reads and LATENCY+2 cycles for writes.
- Reset mid-operation (any non-IDLE state): return to IDLE next cycle.
  - No further beats.
  - No `data_ready_m` or `data_ready` pulse.
  - A write still in WAIT is never committed.
- `req_valid` asserted in the same cycle as `reset`: not accepted.

## Test plan
- Reset then idle: hold `reset` 2 cycles, then release → `req_ready`=1, `busy`=0, all pulses 0, `fill_data`=0.
- Write then fill (LATENCY=4): write addr 0x12 data 0xDEADBEEF accepted at cycle 10 → `data_ready` at cycle 15 only. Read addr 0x13 accepted at cycle 16 → beats at 21–24 with `fill_index` 0–3 covering addresses 0x10–0x13, index 2 = 0xDEADBEEF, `data_ready_m` at 25, `req_ready` at 26.
- Line alignment: preload 0x20–0x23 with 1,2,3,4, read addr 0x23 → beats 1,2,3,4 in order, none from 0x24.
- Back-pressure: hold `req_valid` continuously with a second request during a fill → second request accepted only at the first IDLE cycle; no beat or pulse overlap.
- Reset mid-WAIT on a write of 0xCAFEF00D to 0x40 (reset at WAIT cycle 2) → no `data_ready`; a subsequent fill of 0x40 line returns the old value.
- Reset mid-FILL after beat 1 → `fill_valid` low the next cycle, no `data_ready_m`, `req_ready`=1 one cycle after `reset` deasserts.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: main-memory model behind the cache FSM.
// Serves line fills and write-throughs after a fixed latency.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (busy = ~req_ready)
//   req_rw                1 = write-through, 0 = line fill
//   req_addr, req_wdata   word address, write data
//   fill_valid/index/data line beats, data is 0 when idle
//   data_ready_m          pulse: line fill complete
//   data_ready            pulse: write-through committed
module cache_mem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_rw,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          req_ready,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_index,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          data_ready_m,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_DONE,
    S_WRITE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rdy_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                accept;
  logic [OW-1:0]       next_idx;
  logic [ADDR_W-OW-1:0] line;

  // ready is masked by reset so nothing is taken during reset
  assign req_ready = rdy_q & ~reset;
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign next_idx  = fill_index + OW'(1);
  assign line      = addr_q[ADDR_W-1:OW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rdy_q        <= 1'b1;
      cnt          <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_valid   <= 1'b0;
      fill_index   <= '0;
      fill_data    <= '0;
      data_ready_m <= 1'b0;
      data_ready   <= 1'b0;
    end else begin
      data_ready_m <= 1'b0;
      data_ready   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_WAIT;
            rdy_q   <= 1'b0;
            cnt     <= CW'(LATENCY);
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (rw_q) begin
              state      <= S_WRITE;
              data_ready <= 1'b1;
            end else begin
              // first beat is fetched as FILL is entered
              state      <= S_FILL;
              fill_valid <= 1'b1;
              fill_index <= '0;
              fill_data  <= mem[{line, {OW{1'b0}}}];
            end
          end
        end
        S_FILL: begin
          if (fill_index == LAST) begin
            state        <= S_DONE;
            fill_valid   <= 1'b0;
            fill_index   <= '0;
            fill_data    <= '0;
            data_ready_m <= 1'b1;
          end else begin
            fill_index <= next_idx;
            fill_data  <= mem[{line, next_idx}];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
        end
        S_WRITE: begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          rdy_q        <= 1'b1;
          cnt          <= '0;
          fill_valid   <= 1'b0;
          fill_index   <= '0;
          fill_data    <= '0;
        end
      endcase
    end
  end

  // storage is never cleared; commit happens on the WRITE cycle edge
  always_ff @(posedge clk) begin
    if (!reset && state == S_WRITE) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: randomized scoreboard bench for cache_mem_ctrl.
// Expected events are queued with their cycle stamps at issue.
module tb_cache_mem_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          fill_valid;
  logic [1:0]    fill_index;
  logic [DW-1:0] fill_data;
  logic          data_ready_m;
  logic          data_ready;
  logic          busy;

  cache_mem_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .fill_valid(fill_valid),
    .fill_index(fill_index), .fill_data(fill_data),
    .data_ready_m(data_ready_m), .data_ready(data_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    int          idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [256];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  int            next_free = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per observed event
  int   n_ev;
  int   kind;
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      n_ev = int'(fill_valid) + int'(data_ready_m) + int'(data_ready);
      if (n_ev > 1) chk("event_overlap", n_ev, 1);
      if (!fill_valid) chk("fill_data_zero", fill_data, 0);
      if (n_ev == 1) begin
        kind = fill_valid ? 0 : (data_ready_m ? 1 : 2);
        if (q.size() == 0) begin
          chk("unexpected_event_kind", kind + 10, 99);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (kind == 0) begin
            chk("beat_index", fill_index, e.idx);
            chk("beat_data", fill_data, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int a);
    int w;
    int start;
    int base;
    int expa;
    start = cyc;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    w = 0;
    while (!req_ready && w < 200) begin
      tick();
      w++;
    end
    if (!req_ready) begin
      chk("accept_timeout", w, 0);
      a = -1;
      req_valid = 1'b0;
      return;
    end
    a = cyc;
    expa = (next_free > start) ? next_free : start;
    chk("accept_cycle", a, expa);
    if (rw) begin
      q.push_back('{2, a + LAT + 1, 0, '0});
      model[addr] = wd;
      next_free = a + LAT + 2;
    end else begin
      base = int'(addr) & ~(LW - 1);
      for (int k = 0; k < LW; k++)
        q.push_back('{0, a + LAT + 1 + k, k, model[base + k]});
      q.push_back('{1, a + LAT + LW + 1, 0, '0});
      next_free = a + LAT + LW + 2;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() > 0 || !req_ready) && w < 300) begin
      tick();
      w++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    int a;
    int a2;
    logic [DW-1:0] old;

    // reset with a request pending: must not be taken
    reset = 1'b1;
    req_valid = 1'b1;
    req_addr = 8'h05;
    tick();
    chk("ready_in_reset", req_ready, 0);
    tick();
    chk("busy_in_reset", busy, 1);
    reset = 1'b0;
    req_valid = 1'b0;
    tick();
    mon_en = 1'b1;
    next_free = cyc;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_index", fill_index, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_data_ready_m", data_ready_m, 0);
    chk("rst_data_ready", data_ready, 0);
    tick();
    tick();

    // preload region 0x00..0x47
    for (int i = 0; i < 'h48; i++) begin
      do_req(1'b1, AW'(i), DW'($urandom), a);
    end
    drain();

    // write then fill, read-after-write
    do_req(1'b1, 8'h12, 32'hDEADBEEF, a);
    do_req(1'b0, 8'h13, '0, a2);
    chk("raw_spacing", a2 - a, LAT + 2);
    drain();

    // line alignment
    for (int i = 0; i < 4; i++) do_req(1'b1, AW'('h20 + i), DW'(i + 1), a);
    do_req(1'b0, 8'h23, '0, a);
    drain();

    // back-pressure: second request held during fill
    do_req(1'b0, 8'h2A, '0, a);
    do_req(1'b1, 8'h2B, 32'h13572468, a2);
    chk("bp_accept", a2 - a, LAT + LW + 2);
    do_req(1'b0, 8'h28, '0, a);
    drain();

    // random traffic
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 'h3F)),
             DW'($urandom), a);
    end
    drain();

    // reset during WAIT of a write: never committed
    old = model[8'h40];
    tick();
    do_req(1'b1, 8'h40, 32'hCAFEF00D, a);
    model[8'h40] = old;
    tick();
    chk("mid_wait_cycle", cyc, a + 2);
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("post_wait_rst_ready", req_ready, 1);
    next_free = cyc;
    for (int i = 0; i < 6; i++) tick();
    do_req(1'b0, 8'h41, '0, a);
    drain();

    // reset during FILL after beat 1
    tick();
    do_req(1'b0, 8'h06, '0, a);
    while (cyc < a + LAT + 2) tick();
    chk("mid_fill_beat1", fill_index, 1);
    reset = 1'b1;
    q.delete();
    tick();
    chk("fill_stops", fill_valid, 0);
    reset = 1'b0;
    tick();
    chk("post_fill_rst_ready", req_ready, 1);
    next_free = cyc;
    for (int i = 0; i < 8; i++) tick();
    do_req(1'b0, 8'h07, '0, a);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
